// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : phase_sequencer
// Brief    : Machine-cycle controller for a two-phase clocking scheme. Each
//            machine cycle is NUM_STEPS T-states; each T-state is one cycle
//            of phase A followed by one cycle of phase B. Supports free-run,
//            halt-at-cycle-end, single machine-cycle step and wait states.
//            Phase outputs are clock enables on i_base_clock, not clocks.
// Revision : 1.0 - initial release
// ============================================================================
module phase_sequencer #(
  parameter int NUM_STEPS   = 4,
  parameter int STEP_WIDTH  = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_base_clock,
  input  logic                   i_reset,
  input  logic                   i_run,
  input  logic                   i_step,
  input  logic                   i_wait,
  input  logic                   i_halt_req,
  output logic                   o_phase_A,
  output logic                   o_phase_B,
  output logic [STEP_WIDTH-1:0]  o_step,
  output logic                   o_cycle_start,
  output logic                   o_running,
  output logic                   o_halted,
  output logic [COUNT_WIDTH-1:0] o_cycle_count
);

  // Index of the final T-state of a machine cycle.
  localparam logic [STEP_WIDTH-1:0]  c_last_step = STEP_WIDTH'(NUM_STEPS - 1);
  localparam logic [STEP_WIDTH-1:0]  c_step_zero = '0;
  localparam logic [STEP_WIDTH-1:0]  c_step_one  = STEP_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] c_count_one = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_PH_A   = 2'd1,
    ST_PH_B   = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  state_t                  r_state;
  logic [STEP_WIDTH-1:0]   r_step;
  logic                    r_single;
  logic [COUNT_WIDTH-1:0]  r_count;

  state_t                  w_state_nxt;
  logic [STEP_WIDTH-1:0]   w_step_nxt;
  logic                    w_single_nxt;
  logic [COUNT_WIDTH-1:0]  w_count_nxt;
  logic                    w_last_step;

  assign w_last_step = (r_step == c_last_step);

  // State register; reset drops straight to HALTED even between edges.
  always_ff @(posedge i_base_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_HALTED;
      r_step   <= c_step_zero;
      r_single <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_step   <= w_step_nxt;
      r_single <= w_single_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Next-state logic. i_run / i_halt_req only matter in HALTED and at the
  // machine-cycle end, so dropping i_run mid-cycle never truncates a cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_step_nxt   = r_step;
    w_single_nxt = r_single;
    w_count_nxt  = r_count;
    case (r_state)
      ST_HALTED: begin
        w_step_nxt = c_step_zero;
        if (i_run || i_step) begin
          w_state_nxt  = ST_PH_A;
          // Run takes priority over step when both are requested.
          w_single_nxt = ~i_run;
        end
      end
      ST_PH_A: begin
        w_state_nxt = ST_PH_B;
      end
      ST_PH_B, ST_WAIT: begin
        if (i_wait) begin
          w_state_nxt = ST_WAIT;
        end else if (!w_last_step) begin
          w_step_nxt  = r_step + c_step_one;
          w_state_nxt = ST_PH_A;
        end else begin
          // Machine-cycle end: count it, then continue or stop.
          w_count_nxt = r_count + c_count_one;
          w_step_nxt  = c_step_zero;
          if (i_run && !i_halt_req && !r_single) begin
            w_state_nxt = ST_PH_A;
          end else begin
            w_state_nxt  = ST_HALTED;
            w_single_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt  = ST_HALTED;
        w_step_nxt   = c_step_zero;
        w_single_nxt = 1'b0;
      end
    endcase
  end

  // Moore outputs decoded from the registered state.
  assign o_phase_A     = (r_state == ST_PH_A);
  assign o_phase_B     = (r_state == ST_PH_B);
  assign o_step        = r_step;
  assign o_cycle_start = (r_state == ST_PH_A) && (r_step == c_step_zero);
  assign o_running     = (r_state != ST_HALTED);
  assign o_halted      = (r_state == ST_HALTED);
  assign o_cycle_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_sequencer
// Brief    : Self-checking bench for phase_sequencer. Expected observation
//            words are queued when stimulus is applied and popped/compared
//            once per clock at the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic i_reset = 1'b0;
  logic i_run = 1'b0, i_step = 1'b0, i_wait = 1'b0, i_halt_req = 1'b0;
  logic o_phase_A, o_phase_B, o_cycle_start, o_running, o_halted;
  logic [1:0]  o_step;
  logic [15:0] o_cycle_count;

  // Second instance: single T-state, narrow counter for wrap checks.
  logic run1 = 1'b0, step1 = 1'b0, wait1 = 1'b0, halt1_req = 1'b0;
  logic a1, b1, start1, running1, halted1;
  logic [0:0] step1_o;
  logic [3:0] count1;

  int total = 0;
  int bad   = 0;
  int exp_count = 0;
  logic [22:0] exp_q[$];

  always #5 clk = ~clk;

  phase_sequencer #(.NUM_STEPS(4), .STEP_WIDTH(2), .COUNT_WIDTH(16)) u_dut (
    .i_base_clock(clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
    .i_wait(i_wait), .i_halt_req(i_halt_req), .o_phase_A(o_phase_A),
    .o_phase_B(o_phase_B), .o_step(o_step), .o_cycle_start(o_cycle_start),
    .o_running(o_running), .o_halted(o_halted), .o_cycle_count(o_cycle_count)
  );

  phase_sequencer #(.NUM_STEPS(1), .STEP_WIDTH(1), .COUNT_WIDTH(4)) u_dut1 (
    .i_base_clock(clk), .i_reset(i_reset), .i_run(run1), .i_step(step1),
    .i_wait(wait1), .i_halt_req(halt1_req), .o_phase_A(a1),
    .o_phase_B(b1), .o_step(step1_o), .o_cycle_start(start1),
    .o_running(running1), .o_halted(halted1), .o_cycle_count(count1)
  );

  // Expected word: {A, B, step, cycle_start, running, halted, count}.
  function automatic logic [22:0] mk(bit a, bit b, int step, bit halted, int count);
    logic [1:0]  s;
    logic [15:0] c;
    s = step[1:0];
    c = count[15:0];
    return {a, b, s, (a && step == 0), ~halted, halted, c};
  endfunction

  function automatic logic [22:0] obs0();
    return {o_phase_A, o_phase_B, o_step, o_cycle_start, o_running, o_halted, o_cycle_count};
  endfunction

  function automatic logic [22:0] obs1();
    return {a1, b1, 1'b0, step1_o, start1, running1, halted1, 12'h000, count1};
  endfunction

  task automatic test_reset();
    logic [22:0] got, want;
    #2 i_reset = 1'b1;
    #1;
    want = mk(0, 0, 0, 1, 0);
    got = obs0();
    total++;
    if (got !== want) begin bad++; $display("FAIL reset_por got=%h want=%h", got, want); end
    got = obs1();
    total++;
    if (got !== want) begin bad++; $display("FAIL reset_por_dut1 got=%h want=%h", got, want); end
    @(negedge clk);
    i_reset = 1'b0;
    for (int k = 0; k < 2; k++) exp_q.push_back(mk(0, 0, 0, 1, 0));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      got = obs0();
      total++;
      if (got !== want) begin bad++; $display("FAIL reset_idle[%0d] got=%h want=%h", k, got, want); end
    end
    exp_count = 0;
  endtask

  task automatic test_free_run();
    logic [22:0] got, want;
    int c0;
    c0 = exp_count;
    for (int k = 0; k < 40; k++) exp_q.push_back(mk(k % 2 == 0, k % 2 == 1, (k / 2) % 4, 0, c0 + k / 8));
    exp_q.push_back(mk(0, 0, 0, 1, c0 + 5));
    @(negedge clk);
    i_run = 1'b1;
    for (int k = 0; k < 41; k++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      got = obs0();
      total++;
      if (got !== want) begin bad++; $display("FAIL free_run[%0d] got=%h want=%h", k, got, want); end
      if (k == 34) i_run = 1'b0;   // mid-cycle drop must not truncate
    end
    exp_count = c0 + 5;
  endtask

  task automatic test_reset_mid_run();
    logic [22:0] got, want;
    @(negedge clk);
    i_run = 1'b1;
    repeat (5) @(negedge clk);
    #2 i_reset = 1'b1;
    i_run = 1'b0;
    #1;
    want = mk(0, 0, 0, 1, 0);
    got = obs0();
    total++;
    if (got !== want) begin bad++; $display("FAIL reset_async got=%h want=%h", got, want); end
    @(negedge clk);
    i_reset = 1'b0;
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(0, 0, 0, 1, 0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      got = obs0();
      total++;
      if (got !== want) begin bad++; $display("FAIL reset_hold[%0d] got=%h want=%h", k, got, want); end
    end
    exp_count = 0;
  endtask

  task automatic test_wait();
    logic [22:0] got, want;
    int c0;
    // 0=phase A, 1=phase B, 2=wait
    int ph[11] = '{0, 1, 0, 1, 2, 2, 2, 0, 1, 0, 1};
    int st[11] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 3, 3};
    c0 = exp_count;
    for (int k = 0; k < 11; k++) exp_q.push_back(mk(ph[k] == 0, ph[k] == 1, st[k], 0, c0));
    exp_q.push_back(mk(0, 0, 0, 1, c0 + 1));
    @(negedge clk);
    i_run = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      got = obs0();
      total++;
      if (got !== want) begin bad++; $display("FAIL wait[%0d] got=%h want=%h", k, got, want); end
      if (k == 3) begin i_wait = 1'b1; i_run = 1'b0; end
      if (k == 6) i_wait = 1'b0;
    end
    exp_count = c0 + 1;
  endtask

  task automatic test_halt();
    logic [22:0] got, want;
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    for (int k = 0; k < 16; k++) exp_q.push_back(mk(k % 2 == 0, k % 2 == 1, (k / 2) % 4, 0, k / 8));
    exp_q.push_back(mk(0, 0, 0, 1, 2));
    for (int j = 0; j < 8; j++) exp_q.push_back(mk(j % 2 == 0, j % 2 == 1, j / 2, 0, 2));
    exp_q.push_back(mk(0, 0, 0, 1, 3));
    @(negedge clk);
    i_run = 1'b1;
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      got = obs0();
      total++;
      if (got !== want) begin bad++; $display("FAIL halt[%0d] got=%h want=%h", k, got, want); end
      if (k == 10) i_halt_req = 1'b1;   // raised in step 1 of cycle 2
      if (k == 16) i_halt_req = 1'b0;   // run still high: restart next edge
      if (k == 17) i_run = 1'b0;
    end
    exp_count = 3;
  endtask

  task automatic test_single_step();
    logic [22:0] got, want;
    int c0;
    c0 = exp_count;
    for (int k = 0; k < 8; k++) exp_q.push_back(mk(k % 2 == 0, k % 2 == 1, k / 2, 0, c0));
    for (int k = 0; k < 2; k++) exp_q.push_back(mk(0, 0, 0, 1, c0 + 1));
    @(negedge clk);
    i_step = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      got = obs0();
      total++;
      if (got !== want) begin bad++; $display("FAIL single_step[%0d] got=%h want=%h", k, got, want); end
      if (k == 0) i_step = 1'b0;
      if (k == 3) i_step = 1'b1;    // must be ignored while running
      if (k == 4) i_step = 1'b0;
    end
    exp_count = c0 + 1;
  endtask

  task automatic test_step_and_run();
    logic [22:0] got, want;
    int c0;
    c0 = exp_count;
    for (int k = 0; k < 16; k++) exp_q.push_back(mk(k % 2 == 0, k % 2 == 1, (k / 2) % 4, 0, c0 + k / 8));
    exp_q.push_back(mk(0, 0, 0, 1, c0 + 2));
    @(negedge clk);
    i_run = 1'b1;
    i_step = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      got = obs0();
      total++;
      if (got !== want) begin bad++; $display("FAIL step_and_run[%0d] got=%h want=%h", k, got, want); end
      if (k == 0) i_step = 1'b0;
      if (k == 8) i_run = 1'b0;
    end
    exp_count = c0 + 2;
  endtask

  task automatic test_wrap();
    logic [22:0] got, want;
    for (int k = 0; k < 36; k++) exp_q.push_back(mk(k % 2 == 0, k % 2 == 1, 0, 0, (k / 2) % 16));
    exp_q.push_back(mk(0, 0, 0, 1, 2));
    @(negedge clk);
    run1 = 1'b1;
    for (int k = 0; k < 37; k++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      got = obs1();
      total++;
      if (got !== want) begin bad++; $display("FAIL wrap[%0d] got=%h want=%h", k, got, want); end
      if (k == 34) run1 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_reset_mid_run();
    test_wait();
    test_halt();
    test_single_step();
    test_step_and_run();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Machine-cycle controller for the two-phase clocking scheme.
- Divides each machine cycle into NUM_STEPS T-states. Each T-state is phase A (one i_base_clock cycle) followed by phase B (one cycle).
- Provides run, halt, single-step and wait-state control.
- Phase outputs are clock enables, not derived clocks. Consumers stay on i_base_clock and qualify on o_phase_A / o_phase_B.

Parameters:
NUM_STEPS, 4, T-states per machine cycle; legal range >=1
STEP_WIDTH, 2, width of o_step; must satisfy 2**STEP_WIDTH >= NUM_STEPS
COUNT_WIDTH, 16, width of completed-machine-cycle counter

Ports:
i_base_clock  input  1  single system clock; all state changes on posedge
i_reset  input  1  asynchronous, active-high reset
i_run  input  1  level; high = free-run consecutive machine cycles
i_step  input  1  request one machine cycle; honoured only in HALTED
i_wait  input  1  level; stretches the current T-state after phase B
i_halt_req  input  1  stop at the end of the current machine cycle
o_phase_A  output  1  high for the one cycle of phase A of each T-state
o_phase_B  output  1  high for the one cycle of phase B of each T-state
o_step  output  STEP_WIDTH  current T-state index, 0..NUM_STEPS-1
o_cycle_start  output  1  high when o_phase_A && o_step==0
o_running  output  1  high in any state other than HALTED
o_halted  output  1  high in HALTED
o_cycle_count  output  COUNT_WIDTH  completed machine cycles; wraps to 0

Behaviour:
- Reset (asynchronous, immediate, also mid-cycle):
  - state=HALTED, step=0, count=0, single-step flag=0.
  - o_halted=1; all other outputs 0.
- Output timing: Moore outputs, decoded from registered state.
- States: HALTED, PH_A, PH_B, WAIT.
- HALTED (phases 0, step held at 0):
  - i_run=1 at an edge -> PH_A, step 0, single=0.
  - Else i_step=1 -> PH_A, step 0, single=1.
  - Both high -> run mode (single=0).
  - First o_phase_A is high in the cycle after the sampling edge.
- PH_A -> PH_B unconditionally; i_wait is ignored in PH_A.
- PH_B:
  - i_wait=1 -> WAIT.
  - Else perform "step end".
- WAIT (phases 0, step held): stays while i_wait=1; i_wait=0 -> "step end".
- Step end:
  - If step < NUM_STEPS-1: step+1, -> PH_A.
  - Else (machine-cycle end): count+1 (modulo 2**COUNT_WIDTH), then:
    - next = PH_A with step 0 if i_run=1 && i_halt_req=0 && single=0;
    - otherwise next = HALTED with step 0 and single cleared.
- Sampling rules:
  - i_run and i_halt_req are sampled only at machine-cycle end. Deasserting i_run mid-cycle never truncates a cycle.
  - i_step is ignored outside HALTED.
- NUM_STEPS=1: every PH_B is a machine-cycle end. Free-run pattern is A,B,A,B…; count +1 every 2 clocks.
- Free-run period with no waits: 2*NUM_STEPS clocks per machine cycle. o_phase_A and o_phase_B are never high simultaneously and never both high in any state.
- o_cycle_count increments on the same edge that leaves the last T-state. The new value is visible coincident with the next o_cycle_start or with o_halted.

Test Plan:
- Reset: assert i_reset mid-run (asynchronously, between edges) -> outputs immediately o_halted=1, phases 0, o_step=0, o_cycle_count=0; stay so while i_run=0.
- Free-run, NUM_STEPS=4: i_run=1 held 32 clocks -> o_phase_A/o_phase_B alternate starting cycle after enable; o_step 0,0,1,1,2,2,3,3 repeating; o_cycle_start every 8 clocks; o_cycle_count=4 after 32 clocks.
- Wait state: i_wait=1 for 3 clocks starting during PH_B of step 1 -> 3 cycles with both phases 0 and o_step=1; then PH_A with o_step=2; machine cycle lasts 11 clocks.
- Halt: pulse i_halt_req during step 1 of cycle 2 -> cycle completes through step 3; o_halted=1 next cycle; o_cycle_count=2; stays halted with i_run=1, i_halt_req=0 until i_run is re-sampled in HALTED (next edge restarts).
- Single step: i_run=0, 1-clock i_step pulse -> exactly 8 phase cycles, then HALTED, count +1; i_step pulse during that cycle has no effect.
- Wrap: COUNT_WIDTH=4, NUM_STEPS=1, free-run 34 clocks -> o_cycle_count sequence reaches 15 then 0, ends at 1.
